// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback stage in front of an 8-bit ALU.
// Optional build macro ZERO_FLAG_EN adds a zero_flag output set on writeback.
module alu_issue_ctrl #(
    parameter int DW    = 8,
    parameter int NREGS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_co,
    output logic          carry_flag,
    output logic          done,
    output logic          illegal,
    input  logic [1:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
`ifdef ZERO_FLAG_EN
    ,
    output logic          zero_flag
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   ir;
    logic [DW-1:0] regs [NREGS];

    logic [2:0]    op;
    logic          use_imm;
    logic [1:0]    rd;
    logic [1:0]    rs1;
    logic [1:0]    rs2;
    logic [DW-1:0] imm;
    logic          bad_op;
    logic          carry_op;

    assign op       = ir[15:13];
    assign use_imm  = ir[12];
    assign rd       = ir[11:10];
    assign rs1      = ir[9:8];
    assign rs2      = ir[7:6];
    assign imm      = DW'(ir[7:0]);
    assign bad_op   = (op == 3'b100) || (op == 3'b101);
    assign carry_op = (op == 3'b000) || (op == 3'b001) || (op == 3'b011);

    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = DECODE;
                end
            end
            DECODE:  state_nxt = bad_op ? IDLE : EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU ports only move in DECODE, so they hold the last operands while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir         <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_sel    <= '0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
`ifdef ZERO_FLAG_EN
            zero_flag  <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir <= instr;
                    end
                end
                DECODE: begin
                    if (bad_op) begin
                        illegal <= 1'b1;
                    end else begin
                        alu_sel <= op;
                        if (use_imm) begin
                            alu_op1 <= imm;
                            alu_op2 <= regs[rs1];
                        end else begin
                            alu_op1 <= regs[rs1];
                            alu_op2 <= regs[rs2];
                        end
                    end
                end
                EXEC: begin
                    regs[rd] <= alu_out;
                    done     <= 1'b1;
                    if (carry_op) begin
                        carry_flag <= alu_co;
                    end
`ifdef ZERO_FLAG_EN
                    zero_flag <= (alu_out == '0);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural ALU.
// Define ZERO_FLAG_EN to exercise the optional zero_flag output.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  alu_op1;
    logic [7:0]  alu_op2;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        alu_co;
    logic        carry_flag;
    logic        done;
    logic        illegal;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;
`ifdef ZERO_FLAG_EN
    logic        zero_flag;
`endif

    alu_issue_ctrl #(.DW(8), .NREGS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_co      (alu_co),
        .carry_flag  (carry_flag),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`ifdef ZERO_FLAG_EN
        ,
        .zero_flag   (zero_flag)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 000 add, 001 sub (co=borrow), 010 xnor, 011 shl, 110 and, 111 mov op1
    function automatic logic [8:0] alu_f(input logic [2:0] s,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (s)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {(a < b), a - b};
            3'b010:  return {1'b0, ~(a ^ b)};
            3'b011:  return {a[7], a[6:0], 1'b0};
            3'b110:  return {1'b0, a & b};
            3'b111:  return {1'b0, a};
            default: return 9'h0;
        endcase
    endfunction

    always_comb begin
        {alu_co, alu_out} = alu_f(alu_sel, alu_op1, alu_op2);
    end

    typedef struct {
        logic [1:0] rd;
        logic [7:0] val;
        logic       cy;
        logic       z;
        int         when;
    } exp_t;

    exp_t        exp_q[$];
    int          ill_q[$];
    logic [15:0] prog[$];
    logic [7:0]  mr[4];
    logic        mc;
    int          checks = 0;
    int          errors = 0;
    int          xfers;
    int          first_acc;
    int          last_done;

    function automatic void predict(input logic [15:0] ins, input int c);
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] r;
        exp_t       e;
        op = ins[15:13];
        if (op == 3'b100 || op == 3'b101) begin
            ill_q.push_back(c + 2);
            return;
        end
        a = ins[12] ? ins[7:0] : mr[ins[9:8]];
        b = ins[12] ? mr[ins[9:8]] : mr[ins[7:6]];
        r = alu_f(op, a, b);
        mr[ins[11:10]] = r[7:0];
        if (op == 3'b000 || op == 3'b001 || op == 3'b011) mc = r[8];
        e.rd   = ins[11:10];
        e.val  = r[7:0];
        e.cy   = mc;
        e.z    = (r[7:0] == 8'h00);
        e.when = c + 3;
        exp_q.push_back(e);
    endfunction

    // Streams prog with instr_valid held high; scores done/illegal pulses.
    task automatic run_prog(input int budget);
        int   spent;
        exp_t e;
        int   w;
        spent     = 0;
        xfers     = 0;
        first_acc = -1;
        last_done = -1;
        @(negedge clk);
        instr_valid = (prog.size() > 0);
        instr       = (prog.size() > 0) ? prog[0] : 16'h0;
        while ((prog.size() > 0 || exp_q.size() > 0 || ill_q.size() > 0)
               && spent < budget) begin
            if (done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done=1 required 0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    last_done = cyc;
                    if (cyc != e.when) begin
                        errors++;
                        $display("FAIL done_latency: cycle %0d required %0d", cyc, e.when);
                    end
                    dbg_addr = e.rd;
                    #1;
                    checks++;
                    if (dbg_data !== e.val) begin
                        errors++;
                        $display("FAIL wb_R%0d: got %h required %h", e.rd, dbg_data, e.val);
                    end
                    checks++;
                    if (carry_flag !== e.cy) begin
                        errors++;
                        $display("FAIL carry: got %b required %b", carry_flag, e.cy);
                    end
`ifdef ZERO_FLAG_EN
                    checks++;
                    if (zero_flag !== e.z) begin
                        errors++;
                        $display("FAIL zero_flag: got %b required %b", zero_flag, e.z);
                    end
`endif
                end
            end
            if (illegal === 1'b1) begin
                checks++;
                if (ill_q.size() == 0) begin
                    errors++;
                    $display("FAIL illegal_unexpected: illegal=1 required 0 at cycle %0d", cyc);
                end else begin
                    w = ill_q.pop_front();
                    if (cyc != w || instr_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL illegal_timing: cycle %0d ready %b required cycle %0d ready 1",
                                 cyc, instr_ready, w);
                    end
                end
            end
            if (instr_valid && instr_ready === 1'b1) begin
                predict(prog[0], cyc);
                if (first_acc < 0) first_acc = cyc;
                xfers++;
                void'(prog.pop_front());
            end
            @(posedge clk);
            spent++;
            #1;
            instr_valid = (prog.size() > 0);
            instr       = (prog.size() > 0) ? prog[0] : 16'h0;
            @(negedge clk);
        end
        checks++;
        if (spent >= budget) begin
            errors++;
            $display("FAIL timeout: %0d cycles, %0d results and %0d illegals outstanding",
                     spent, exp_q.size(), ill_q.size());
            exp_q.delete();
            ill_q.delete();
            prog.delete();
            instr_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: done=%b illegal=%b required 0 0", done, illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", instr_ready);
        end
        checks++;
        if ({alu_op1, alu_op2, alu_sel} !== 19'h0 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_ports: op1=%h op2=%h sel=%h cf=%b required all 0",
                     alu_op1, alu_op2, alu_sel, carry_flag);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_R%0d: got %h required 00", i, dbg_data);
            end
        end
    endtask

    task automatic test_alu_ops;
        prog = '{16'hF4F0, 16'h1920, 16'hFC0F, 16'h41C0};
        run_prog(60);
        dbg_addr = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 8'h10) begin
            errors++;
            $display("FAIL add_R2: got %h required 10", dbg_data);
        end
        dbg_addr = 2'd0;
        #1;
        checks++;
        if (dbg_data !== 8'h00 || carry_flag !== 1'b1) begin
            errors++;
            $display("FAIL xnor_R0: got %h cf=%b required 00 cf=1", dbg_data, carry_flag);
        end
        checks++;
        if (alu_op1 !== 8'hF0 || alu_op2 !== 8'h0F || alu_sel !== 3'b010) begin
            errors++;
            $display("FAIL ports_hold: %h %h %b required f0 0f 010", alu_op1, alu_op2, alu_sel);
        end
    endtask

    task automatic test_illegal;
        prog = '{16'h8000, 16'hA000};
        run_prog(20);
        checks++;
        if (alu_op1 !== 8'hF0 || alu_op2 !== 8'h0F || alu_sel !== 3'b010
            || carry_flag !== 1'b1) begin
            errors++;
            $display("FAIL illegal_side_effect: %h %h %b cf=%b required f0 0f 010 cf=1",
                     alu_op1, alu_op2, alu_sel, carry_flag);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++;
            if (dbg_data !== mr[i]) begin
                errors++;
                $display("FAIL illegal_R%0d: got %h required %h", i, dbg_data, mr[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        prog = '{16'h3D10, 16'h6500, 16'hC9C0, 16'h0280};
        run_prog(40);
        checks++;
        if (xfers != 4) begin
            errors++;
            $display("FAIL b2b_xfers: got %0d required 4", xfers);
        end
        checks++;
        if (last_done - first_acc > 12 || last_done < 0) begin
            errors++;
            $display("FAIL b2b_span: got %0d cycles required <= 12", last_done - first_acc);
        end
        dbg_addr = 2'd0;
        #1;
        checks++;
        if (dbg_data !== 8'h40 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL b2b_R0: got %h cf=%b required 40 cf=0", dbg_data, carry_flag);
        end
    endtask

`ifdef ZERO_FLAG_EN
    task automatic test_zero_flag;
        prog = '{16'hF400};
        run_prog(20);
        checks++;
        if (zero_flag !== 1'b1) begin
            errors++;
            $display("FAIL zf_set: got %b required 1", zero_flag);
        end
        prog = '{16'hF405, 16'h8000};
        run_prog(20);
        checks++;
        if (zero_flag !== 1'b0) begin
            errors++;
            $display("FAIL zf_clear_hold: got %b required 0", zero_flag);
        end
    endtask
`endif

    task automatic test_reset_exec;
        int bad;
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'h1920;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (alu_op1 !== 8'h20 || alu_op2 !== mr[1] || alu_sel !== 3'b000) begin
            errors++;
            $display("FAIL exec_ports: %h %h %b required 20 %h 000", alu_op1, alu_op2,
                     alu_sel, mr[1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_op1, alu_op2, alu_sel} !== 19'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: ports %h %h %h done %b required 0", alu_op1, alu_op2,
                     alu_sel, done);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mc  = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_done: %0d done pulses required 0", bad);
        end
        dbg_addr = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 8'h00 || carry_flag !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec_R2: got %h cf=%b rdy=%b required 00 0 1", dbg_data,
                     carry_flag, instr_ready);
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0;
        dbg_addr    = 2'd0;
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mc = 1'b0;
        test_reset();
        test_alu_ops();
        test_illegal();
        test_back_to_back();
`ifdef ZERO_FLAG_EN
        test_zero_flag();
`endif
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
